// File: rtl/fduart_gen2_if.sv
// fduart_gen2_if: CPU-side register bus of the UART (TX write, RX read, divisor, status)
interface fduart_gen2_if;
    logic [15:0] data_in;
    logic [15:0] arx_reg_out;
    logic [15:0] status_out;
    logic atx_reg_load;
    logic div_reg_load;
    logic arx_reg_read;
    logic status_clear;
    modport master (
        output data_in, atx_reg_load, div_reg_load, arx_reg_read, status_clear,
        input arx_reg_out, status_out
    );
    modport slave (
        input data_in, atx_reg_load, div_reg_load, arx_reg_read, status_clear,
        output arx_reg_out, status_out
    );
endinterface

// File: rtl/fduart_gen2.sv
// fduart_gen2: full-duplex UART with TX/RX FIFOs, runtime baud divisor, optional parity and sticky errors
module fduart_gen2 #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW = 4,
    parameter bit PARITY_EN = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS = 1,
    parameter logic [15:0] DEFAULT_DIV = 16'd433,
    parameter logic LINE_IDLE_LEVEL = 1'b1,
    parameter logic LINE_DATA_INVERT = 1'b0
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic async_rx_line,
    output logic async_tx_line,
    fduart_gen2_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t tx_state, tx_state_n, rx_state, rx_state_n;
    logic [DATA_BITS-1:0] tx_mem [DEPTH];
    logic [DATA_BITS-1:0] rx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_AW:0] tx_cnt, rx_cnt;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_wr;
    logic tx_empty, tx_full, rx_empty, rx_full, tx_busy, rx_busy;
    logic [15:0] div_reg, div_eff;
    logic [15:0] tx_cyc, tx_cyc_n, tx_div, tx_div_n;
    logic [15:0] rx_cyc, rx_cyc_n, rx_div, rx_div_n;
    logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] tx_byte, tx_byte_n, rx_byte, rx_byte_n;
    logic [16:0] rx_hp;
    logic tx_end, tx_line_n, rx_end, rx_half, rx_s1, rx_s2;
    logic ferr, perr, ovr, ferr_set, perr_set;

    assign div_eff = div_reg < 16'd3 ? 16'd3 : div_reg;
    assign tx_empty = tx_cnt == '0;
    assign tx_full = tx_cnt[FIFO_AW];
    assign rx_empty = rx_cnt == '0;
    assign rx_full = rx_cnt[FIFO_AW];
    assign tx_push = bus.atx_reg_load && (!tx_full || tx_pop);
    assign rx_pop = bus.arx_reg_read && !rx_empty;
    assign rx_wr = rx_push && (!rx_full || rx_pop);
    assign tx_busy = tx_state != IDLE || !tx_empty;
    assign rx_busy = rx_state != IDLE && !rx_push;
    assign bus.arx_reg_out = rx_empty ? 16'd0 : 16'(rx_mem[rx_rp]);
    assign bus.status_out = {7'd0, ovr, perr, ferr, rx_busy, tx_busy, rx_full, rx_empty, tx_full, tx_empty};

    assign tx_end = tx_cyc == tx_div;
    always_comb begin
        tx_state_n = tx_state;
        tx_cyc_n = tx_end ? '0 : tx_cyc + 1'b1;
        tx_bit_n = tx_bit;
        tx_byte_n = tx_byte;
        tx_div_n = tx_div;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE: tx_cyc_n = '0;
            START: if (tx_end) tx_state_n = DATA;
            DATA: if (tx_end) begin
                tx_bit_n = tx_bit + 1'b1;
                if (tx_bit == 3'(DATA_BITS - 1)) begin
                    tx_bit_n = '0;
                    tx_state_n = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: if (tx_end) tx_state_n = STOP;
            STOP: if (tx_end) begin
                tx_bit_n = tx_bit + 1'b1;
                if (tx_bit == 3'(STOP_BITS - 1)) begin
                    tx_bit_n = '0;
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
        // the final stop cycle may load the next byte directly so frames stay contiguous
        if (!tx_empty && (tx_state == IDLE || (tx_state == STOP && tx_state_n == IDLE))) begin
            tx_pop = 1'b1;
            tx_state_n = START;
            tx_cyc_n = '0;
            tx_bit_n = '0;
            tx_byte_n = tx_mem[tx_rp];
            tx_div_n = div_eff;
        end
        tx_line_n = tx_state_n == START ? ~LINE_IDLE_LEVEL :
                    tx_state_n == DATA ? tx_byte_n[tx_bit_n] ^ LINE_DATA_INVERT :
                    tx_state_n == PARITY ? ^tx_byte_n ^ PARITY_ODD ^ LINE_DATA_INVERT :
                    LINE_IDLE_LEVEL;
    end

    assign rx_end = rx_cyc == rx_div;
    assign rx_hp = ({1'b0, rx_div} + 17'd1) >> 1;
    assign rx_half = ({1'b0, rx_cyc} + 17'd1) == rx_hp;
    always_comb begin
        rx_state_n = rx_state;
        rx_cyc_n = rx_cyc + 1'b1;
        rx_bit_n = rx_bit;
        rx_byte_n = rx_byte;
        rx_div_n = rx_div;
        rx_push = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cyc_n = '0;
                if (rx_s2 != LINE_IDLE_LEVEL) begin
                    rx_state_n = START;
                    rx_div_n = div_eff;
                end
            end
            START: if (rx_half) begin
                rx_cyc_n = '0;
                rx_bit_n = '0;
                rx_state_n = rx_s2 == LINE_IDLE_LEVEL ? IDLE : DATA;
            end
            DATA: if (rx_end) begin
                rx_cyc_n = '0;
                rx_byte_n[rx_bit] = rx_s2 ^ LINE_DATA_INVERT;
                rx_bit_n = rx_bit + 1'b1;
                if (rx_bit == 3'(DATA_BITS - 1)) rx_state_n = PARITY_EN ? PARITY : STOP;
            end
            PARITY: if (rx_end) begin
                rx_cyc_n = '0;
                perr_set = (rx_s2 ^ LINE_DATA_INVERT) != (^rx_byte ^ PARITY_ODD);
                rx_state_n = STOP;
            end
            STOP: if (rx_end) begin
                rx_cyc_n = '0;
                rx_push = 1'b1;
                ferr_set = rx_s2 != LINE_IDLE_LEVEL;
                rx_state_n = IDLE;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.data_in[DATA_BITS-1:0];
        if (rx_wr) rx_mem[rx_wp] <= rx_byte;
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            tx_cnt <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_cnt <= '0;
            div_reg <= DEFAULT_DIV;
            tx_state <= IDLE;
            tx_cyc <= '0;
            tx_bit <= '0;
            tx_byte <= '0;
            tx_div <= DEFAULT_DIV;
            async_tx_line <= LINE_IDLE_LEVEL;
            rx_state <= IDLE;
            rx_cyc <= '0;
            rx_bit <= '0;
            rx_byte <= '0;
            rx_div <= DEFAULT_DIV;
            rx_s1 <= LINE_IDLE_LEVEL;
            rx_s2 <= LINE_IDLE_LEVEL;
            ferr <= 1'b0;
            perr <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + {{FIFO_AW{1'b0}}, tx_push} - {{FIFO_AW{1'b0}}, tx_pop};
            if (rx_wr) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + {{FIFO_AW{1'b0}}, rx_wr} - {{FIFO_AW{1'b0}}, rx_pop};
            if (bus.div_reg_load) div_reg <= bus.data_in;
            tx_state <= tx_state_n;
            tx_cyc <= tx_cyc_n;
            tx_bit <= tx_bit_n;
            tx_byte <= tx_byte_n;
            tx_div <= tx_div_n;
            async_tx_line <= tx_line_n;
            rx_state <= rx_state_n;
            rx_cyc <= rx_cyc_n;
            rx_bit <= rx_bit_n;
            rx_byte <= rx_byte_n;
            rx_div <= rx_div_n;
            rx_s1 <= async_rx_line;
            rx_s2 <= rx_s1;
            ferr <= ferr_set || (ferr && !bus.status_clear);
            perr <= perr_set || (perr && !bus.status_clear);
            ovr <= (rx_push && rx_full && !rx_pop) || (ovr && !bus.status_clear);
        end
    end
endmodule

// File: tb/tb_fduart_gen2.sv
// tb_fduart_gen2: scoreboard bench; u0 runs 8N1 in loopback, u1 has parity, a 4-deep FIFO and an injected rx line
module tb_fduart_gen2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx1 = 1'b1;
    wire line0, tx1;
    int checks = 0, fails = 0;
    bit mon1_en = 1'b1;
    logic [7:0] q0[$], q1[$];
    always #5 clk = ~clk;

    fduart_gen2_if b0 ();
    fduart_gen2_if b1 ();
    fduart_gen2 u0 (.sysclk(clk), .sysreset(rst), .async_rx_line(line0), .async_tx_line(line0), .bus(b0));
    fduart_gen2 #(.FIFO_AW(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .DEFAULT_DIV(16'd3)) u1 (
        .sysclk(clk), .sysreset(rst), .async_rx_line(rx1), .async_tx_line(tx1), .bus(b1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // RX monitors: whenever a FIFO head is presented, compare it with the oldest expected byte and pop
    initial begin
        b0.arx_reg_read = 1'b0;
        forever begin
            tick();
            if (b0.arx_reg_read || rst) b0.arx_reg_read = 1'b0;
            else if (!b0.status_out[2]) begin
                if (q0.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rx0 unexpected byte: got %0h, expected none", b0.arx_reg_out);
                end else chk("rx0 byte", b0.arx_reg_out, {24'd0, q0.pop_front()});
                b0.arx_reg_read = 1'b1;
            end
        end
    end

    initial begin
        b1.arx_reg_read = 1'b0;
        forever begin
            tick();
            if (b1.arx_reg_read || rst) b1.arx_reg_read = 1'b0;
            else if (mon1_en && !b1.status_out[2]) begin
                if (q1.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rx1 unexpected byte: got %0h, expected none", b1.arx_reg_out);
                end else chk("rx1 byte", b1.arx_reg_out, {24'd0, q1.pop_front()});
                b1.arx_reg_read = 1'b1;
            end
        end
    end

    task automatic wr0(input logic [7:0] d);
        b0.data_in = {8'd0, d};
        b0.atx_reg_load = 1'b1;
        q0.push_back(d);
        tick();
        b0.atx_reg_load = 1'b0;
    endtask

    task automatic setdiv0(input logic [15:0] v);
        b0.data_in = v;
        b0.div_reg_load = 1'b1;
        tick();
        b0.div_reg_load = 0;
    endtask

    task automatic waitlow0();
        int n = 0;
        while (line0 !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            fails++;
            $display("FAIL tx0 start bit: got no start level within 60 cycles, expected one");
        end
    endtask

    // Expected tx waveform: each frame is start, LSB-first data, stop, every bit (div+1) cycles, no gaps
    task automatic wave0(input logic [7:0] d [$], input int dv [$], input int load_k);
        int k = 0;
        logic [9:0] fr;
        for (int f = 0; f < d.size(); f++) begin
            fr = {1'b1, d[f], 1'b0};
            for (int i = 0; i < 10 * (dv[f] + 1); i++) begin
                if (k == load_k) begin
                    b0.data_in = 16'd9;
                    b0.div_reg_load = 1'b1;
                end
                if (k == load_k + 1) b0.div_reg_load = 1'b0;
                chk("tx0 line", line0, fr[i / (dv[f] + 1)]);
                k++;
                tick();
            end
        end
        chk("tx0 idle after frames", line0, 1);
    endtask

    task automatic burst0(input logic [7:0] d [$], input int dv [$], input int load_k);
        fork
            foreach (d[i]) wr0(d[i]);
            begin
                waitlow0();
                wave0(d, dv, load_k);
            end
        join
    endtask

    task automatic drain0();
        int n = 0;
        while ((q0.size() != 0 || !b0.status_out[2]) && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 600) begin
            fails++;
            $display("FAIL rx0 drain: got %0d bytes outstanding, expected 0", q0.size());
        end
    endtask

    task automatic drain1();
        int n = 0;
        while ((q1.size() != 0 || !b1.status_out[2]) && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 600) begin
            fails++;
            $display("FAIL rx1 drain: got %0d bytes outstanding, expected 0", q1.size());
        end
    endtask

    task automatic send1(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] fr;
        fr = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx1 = fr[i];
            tick(4);
        end
        rx1 = 1'b1;
        tick(8);
    endtask

    function automatic logic epar(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic clr1();
        b1.status_clear = 1'b1;
        tick();
        b1.status_clear = 1'b0;
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got no end of run, expected one within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$], d;
        int dq[$], dv, n;
        b0.data_in = '0;
        b0.atx_reg_load = 1'b0;
        b0.div_reg_load = 1'b0;
        b0.status_clear = 1'b0;
        b1.data_in = '0;
        b1.atx_reg_load = 1'b0;
        b1.div_reg_load = 1'b0;
        b1.status_clear = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset status0", b0.status_out, 16'h0005);
        chk("reset status1", b1.status_out, 16'h0005);
        chk("reset rx0 head", b0.arx_reg_out, 0);
        chk("reset tx0 line", line0, 1);

        setdiv0(16'd3);
        wr0(8'hA5);
        chk("tx0 not empty before pop", b0.status_out[0], 0);
        chk("tx0 busy on pop cycle", b0.status_out[4], 1);
        tick();
        chk("tx0 start after pop", line0, 0);
        chk("tx0 empty after pop", b0.status_out[0], 1);
        bq = {8'hA5};
        dq = {3};
        wave0(bq, dq, -1);
        drain0();

        bq = {};
        dq = {};
        for (int i = 0; i < 16; i++) begin
            bq.push_back(8'(i));
            dq.push_back(3);
        end
        burst0(bq, dq, -1);
        drain0();
        chk("loopback errors", b0.status_out[8:6], 0);

        for (int r = 0; r < 4; r++) begin
            dv = $urandom_range(7, 0);
            setdiv0(16'(dv));
            n = $urandom_range(6, 1);
            bq = {};
            dq = {};
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                dq.push_back(dv < 3 ? 3 : dv);
            end
            burst0(bq, dq, -1);
            drain0();
            tick($urandom_range(10, 1));
        end
        chk("random loopback errors", b0.status_out[8:6], 0);

        setdiv0(16'd3);
        bq = {8'($urandom), 8'($urandom)};
        dq = {3, 9};
        burst0(bq, dq, 10);
        drain0();

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            q1.push_back(d);
            send1(d, epar(d), 1'b1);
        end
        drain1();
        chk("rx1 clean errors", b1.status_out[8:6], 0);

        q1.push_back(8'h01);
        send1(8'h01, 1'b0, 1'b1);
        drain1();
        chk("parity_err set", b1.status_out[7], 1);
        chk("framing_err after parity frame", b1.status_out[6], 0);
        clr1();
        chk("errors after clear", b1.status_out[8:6], 0);
        d = 8'($urandom);
        q1.push_back(d);
        send1(d, epar(d), 1'b0);
        drain1();
        chk("framing_err set", b1.status_out[6], 1);
        chk("parity_err after framing frame", b1.status_out[7], 0);
        clr1();

        rx1 = 1'b0;
        tick();
        rx1 = 1'b1;
        tick(12);
        chk("glitch rx_busy", b1.status_out[5], 0);
        chk("glitch rx_empty", b1.status_out[2], 1);

        mon1_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            if (i < 4) q1.push_back(d);
            send1(d, epar(d), 1'b1);
            if (i == 3) begin
                chk("rx_full after 4", b1.status_out[3], 1);
                chk("no overrun at 4", b1.status_out[8], 0);
            end
        end
        chk("overrun after 6", b1.status_out[8], 1);
        chk("rx_full after 6", b1.status_out[3], 1);
        clr1();
        chk("overrun cleared", b1.status_out[8], 0);
        mon1_en = 1'b1;
        drain1();

        setdiv0(16'd3);
        wr0(8'h3C);
        waitlow0();
        tick(5);
        rst = 1'b1;
        tick();
        chk("mid-frame reset tx line", line0, 1);
        chk("mid-frame reset status0", b0.status_out, 16'h0005);
        chk("mid-frame reset rx0 head", b0.arx_reg_out, 0);
        rst = 1'b0;
        q0.delete();
        tick(60);
        chk("post-reset status0", b0.status_out, 16'h0005);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
